// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared pixel/lane definitions for the conv datapath
// Lane k of a packed row sits at [k*DATA_WIDTH +: DATA_WIDTH], lane 0 = leftmost column.
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int F          = 3;

  typedef logic signed [DATA_WIDTH-1:0] pixel_t;
  typedef logic [F*DATA_WIDTH-1:0]      row_t;

  function automatic pixel_t row_lane(input row_t row, input int k);
    return pixel_t'(row[k*DATA_WIDTH +: DATA_WIDTH]);
  endfunction

  function automatic row_t row_pack(input pixel_t l0, input pixel_t l1, input pixel_t l2);
    return {l2, l1, l0};
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - DEPTH-deep circular delay line, read-before-write
// dout_o is the sample written DEPTH enables ago; storage is never cleared.
module conv_line_buffer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int DEPTH      = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         ptr_q, ptr_d;

  assign dout_o = mem_q[ptr_q];
  assign ptr_d  = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - raster pixel stream to 3x3 windows, 1-deep held output
// Optional out_last port enabled by macro CONV_WIN_LAST_EN.
module conv_window_buffer #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int F          = conv_pkg::F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [F*DATA_WIDTH-1:0] out_row0,
  output logic [F*DATA_WIDTH-1:0] out_row1,
`ifdef CONV_WIN_LAST_EN
  output logic [F*DATA_WIDTH-1:0] out_row2,
  output logic                    out_last
`else
  output logic [F*DATA_WIDTH-1:0] out_row2
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] win0_q [F];
  logic [DATA_WIDTH-1:0] win1_q [F];
  logic [DATA_WIDTH-1:0] win2_q [F];
  logic [DATA_WIDTH-1:0] win0_d [F];
  logic [DATA_WIDTH-1:0] win1_d [F];
  logic [DATA_WIDTH-1:0] win2_d [F];
  logic                  out_valid_q, out_valid_d;
  logic                  accept, win_done;
  logic [DATA_WIDTH-1:0] lb1_dout, lb2_dout;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Counters gate window validity, so stale line-buffer contents never reach a valid window.
  assign win_done = (row_q >= RW'(2)) && (col_q >= CW'(2));

  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb_r1 (
    .clk(clk), .reset(reset), .en_i(accept), .din_i(in_pixel), .dout_o(lb1_dout)
  );

  conv_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb_r2 (
    .clk(clk), .reset(reset), .en_i(accept), .din_i(lb1_dout), .dout_o(lb2_dout)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win0_d      = win0_q;
    win1_d      = win1_q;
    win2_d      = win2_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int k = 0; k < F-1; k++) begin
        win0_d[k] = win0_q[k+1];
        win1_d[k] = win1_q[k+1];
        win2_d[k] = win2_q[k+1];
      end
      win0_d[F-1] = in_pixel;
      win1_d[F-1] = lb1_dout;
      win2_d[F-1] = lb2_dout;
      out_valid_d = win_done;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < F; k++) begin
        win0_q[k] <= '0;
        win1_q[k] <= '0;
        win2_q[k] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win0_q      <= win0_d;
      win1_q      <= win1_d;
      win2_q      <= win2_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar k = 0; k < F; k++) begin : g_lane
    assign out_row0[k*DATA_WIDTH +: DATA_WIDTH] = win0_q[k];
    assign out_row1[k*DATA_WIDTH +: DATA_WIDTH] = win1_q[k];
    assign out_row2[k*DATA_WIDTH +: DATA_WIDTH] = win2_q[k];
  end

`ifdef CONV_WIN_LAST_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = win_done && (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
    end else if (out_ready) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign out_last = last_q;
`endif

endmodule
